line_buffer_read_scheduler: RTL

- Read-side controller for the shared video line-buffer RAM that the capture path fills.
- Arms on the capture start trigger, then aligns to the output frame and generates per-pixel read addresses line by line.
- Optionally repeats each buffered line (line doubling) and wraps the address at the end of the ring buffer.
- Tracks buffered-line occupancy against write-side line completions and flags underrun/overflow, so the output timing generator can consume the buffer safely.

---
 rtl/line_buffer_read_scheduler_if.sv | 29 ++
 rtl/line_buffer_read_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/line_buffer_read_scheduler_if.sv
// Read-side bus between the line-buffer read scheduler, the output timing
// generator (frame/line/pixel strobes) and the line-buffer RAM read port.
interface line_buffer_read_scheduler_if #(
  parameter int ADDR_BITS = 15
);
  logic                 frame_start;
  logic                 line_start;
  logic                 pixel_active;
  logic [ADDR_BITS-1:0] rdaddr;
  logic                 rden;

  // Scheduler side: consumes timing strobes, drives the RAM read port.
  modport master (
    input  frame_start,
    input  line_start,
    input  pixel_active,
    output rdaddr,
    output rden
  );

  // Timing generator / RAM side.
  modport slave (
    output frame_start,
    output line_start,
    output pixel_active,
    input  rdaddr,
    input  rden
  );
endinterface

// File: rtl/line_buffer_read_scheduler.sv
// Read-side controller for the video line-buffer ring: arms on the capture
// trigger, generates per-pixel read addresses and tracks buffered-line occupancy.
module line_buffer_read_scheduler #(
  parameter int ADDR_BITS   = 15,
  parameter int LINE_LENGTH = 640,
  parameter int NUM_LINES   = 32,
  parameter int V_ACTIVE    = 480
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          starttrigger,
  input  logic                          wr_line_done,
  input  logic                          line_doubler,
  line_buffer_read_scheduler_if.master  rd_bus,
  output logic                          running,
  output logic [9:0]                    line_count,
  output logic                          underrun,
  output logic                          overflow
);

  localparam int X_BITS   = $clog2(LINE_LENGTH + 1);
  localparam int OCC_BITS = $clog2(NUM_LINES + 1);

  localparam logic [ADDR_BITS:0]   LINE_STEP  = (ADDR_BITS + 1)'(LINE_LENGTH);
  localparam logic [ADDR_BITS:0]   RING_WORDS = (ADDR_BITS + 1)'(LINE_LENGTH * NUM_LINES);
  localparam logic [X_BITS-1:0]    X_END      = X_BITS'(LINE_LENGTH);
  localparam logic [X_BITS-1:0]    X_ONE      = X_BITS'(1'b1);
  localparam logic [OCC_BITS-1:0]  OCC_FULL   = OCC_BITS'(NUM_LINES);
  localparam logic [OCC_BITS-1:0]  OCC_ONE    = OCC_BITS'(1'b1);
  localparam logic [OCC_BITS-1:0]  OCC_ZERO   = OCC_BITS'(1'b0);
  localparam logic [9:0]           LC_MAX     = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [ADDR_BITS-1:0]   base_r;
  logic [X_BITS-1:0]      x_r;
  logic                   repeat_r;
  logic                   doubler_r;
  logic                   first_line_r;
  logic [9:0]             line_count_r;
  logic [OCC_BITS-1:0]    occ_r;
  logic                   underrun_r;
  logic                   overflow_r;
  logic [ADDR_BITS-1:0]   rdaddr_r;
  logic                   rden_r;

  logic                   frame_evt_s;
  logic                   line_evt_s;
  logic                   first_start_s;
  logic                   consume_s;
  logic                   rd_hit_s;
  logic [ADDR_BITS:0]     base_sum_s;
  logic [ADDR_BITS-1:0]   base_nxt_s;

  // A line_start coinciding with frame_start counts as the frame's first line.
  assign frame_evt_s   = rd_bus.frame_start && ((state_r == ARMED) || (state_r == RUN));
  assign line_evt_s    = rd_bus.line_start && (state_r == RUN) && !rd_bus.frame_start && !first_line_r;
  assign first_start_s = rd_bus.line_start && (state_r == RUN) && !rd_bus.frame_start && first_line_r;
  assign consume_s     = line_evt_s && !(doubler_r && !repeat_r);
  assign rd_hit_s      = (state_r == RUN) && (line_count_r < LC_MAX) && rd_bus.pixel_active && (x_r < X_END);
  assign base_sum_s    = {1'b0, base_r} + LINE_STEP;
  assign base_nxt_s    = (base_sum_s >= RING_WORDS) ? {ADDR_BITS{1'b0}} : base_sum_s[ADDR_BITS-1:0];

  // Next-state decode for the arm/run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (starttrigger) state_nxt_s = ARMED;
        else              state_nxt_s = IDLE;
      end
      ARMED: begin
        if (rd_bus.frame_start) state_nxt_s = RUN;
        else                    state_nxt_s = ARMED;
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Frame/line position: base address, pixel index, repeat phase, line count.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_r       <= {ADDR_BITS{1'b0}};
      x_r          <= {X_BITS{1'b0}};
      repeat_r     <= 1'b0;
      doubler_r    <= 1'b0;
      first_line_r <= 1'b0;
      line_count_r <= 10'd0;
    end else if (frame_evt_s) begin
      base_r       <= {ADDR_BITS{1'b0}};
      x_r          <= {X_BITS{1'b0}};
      repeat_r     <= 1'b0;
      doubler_r    <= line_doubler;
      first_line_r <= !rd_bus.line_start;
      line_count_r <= 10'd0;
    end else if (line_evt_s) begin
      x_r          <= {X_BITS{1'b0}};
      line_count_r <= (line_count_r == LC_MAX) ? line_count_r : line_count_r + 10'd1;
      if (doubler_r && !repeat_r) begin
        repeat_r <= 1'b1;
      end else begin
        repeat_r <= 1'b0;
        base_r   <= base_nxt_s;
      end
    end else begin
      if (first_start_s) first_line_r <= 1'b0;
      if (rd_hit_s)      x_r          <= x_r + X_ONE;
    end
  end

  // RAM read port: one-cycle latency from pixel_active, address holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rden_r   <= 1'b0;
      rdaddr_r <= {ADDR_BITS{1'b0}};
    end else begin
      rden_r <= rd_hit_s;
      if (rd_hit_s) rdaddr_r <= base_r + ADDR_BITS'(x_r);
    end
  end

  // Buffered-line occupancy with sticky underrun/overflow flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_r      <= OCC_ZERO;
      underrun_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case ({wr_line_done, consume_s})
        2'b10: begin
          if (occ_r == OCC_FULL) overflow_r <= 1'b1;
          else                   occ_r      <= occ_r + OCC_ONE;
        end
        2'b01: begin
          if (occ_r == OCC_ZERO) underrun_r <= 1'b1;
          else                   occ_r      <= occ_r - OCC_ONE;
        end
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign rd_bus.rdaddr = rdaddr_r;
  assign rd_bus.rden   = rden_r;
  assign running       = (state_r == RUN);
  assign line_count    = line_count_r;
  assign underrun      = underrun_r;
  assign overflow      = overflow_r;

endmodule
